ball_motion_controller: RTL and testbench
=========================================

Name: ball_motion_controller

Overview:
Per-ball kinematics stage directly downstream of the collision controller. Holds ball position and velocity in fixed point and integrates position once per frame. Applies rolling friction and reflects velocity on each collision pulse. Drives the ball's top-left coordinate to the ball drawing object.

Parameters:
INIT_X, 320, reset/respawn X in whole pixels
INIT_Y, 240, reset/respawn Y in whole pixels
FRAC_BITS, 6, fractional bits of position and velocity (1/64 pixel)
FRICTION_SHIFT, 4, per-frame velocity decay: v -= v>>>FRICTION_SHIFT
MIN_SPEED, 16, |v| threshold (fixed-point units) below which an axis is zeroed
X_MIN, 32, lowest legal topLeftX (pixels); X_MAX, 600, highest
Y_MIN, 32, lowest legal topLeftY; Y_MAX, 440, highest

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous reset, active-high (resetN=1 resets), despite the name
startOfFrame  in  1  one-cycle pulse per frame
SingleHitPulse  in  1  one-cycle collision pulse from the collision controller
hit_x  in  1  collision is against a vertical edge (negate vx); sampled with SingleHitPulse
hit_y  in  1  collision is against a horizontal edge (negate vy); sampled with SingleHitPulse
strike_valid  in  1  cue strike request
strike_vx  in  11 signed  strike X velocity, fixed point
strike_vy  in  11 signed  strike Y velocity, fixed point
strike_ready  out  1  1 when a strike is accepted (state IDLE)
topLeftX  out  11 signed  ball X in whole pixels (pos_x>>>FRAC_BITS)
topLeftY  out  11 signed  ball Y in whole pixels
moving  out  1  1 in state MOVING
ball_stopped  out  1  one-cycle pulse on MOVING->IDLE

Behaviour:
- Internal state: pos_x, pos_y (11+FRAC_BITS signed); vx, vy (11 signed); FSM {IDLE, MOVING}; per-frame reflect flag.
- Reset (async, resetN=1): pos = INIT<<FRAC_BITS; vx = vy = 0; state IDLE; flag 0; strike_ready 1, moving 0, ball_stopped 0, topLeftX = INIT_X, topLeftY = INIT_Y. Reset mid-motion aborts the motion immediately with no stopped pulse.
- All outputs are registered. topLeft reflects the new position in the cycle after the update.
- IDLE: strike_valid=1 -> load vx, vy from strike_vx, strike_vy; go to MOVING next cycle. A strike with both components 0 is ignored. SingleHitPulse is ignored. No integration occurs.
- Strike and startOfFrame in the same cycle in IDLE: the strike loads; no integration that frame.
- MOVING: strike_valid is ignored (strike_ready=0).
- MOVING, SingleHitPulse=1 and flag=0: vx = -vx if hit_x; vy = -vy if hit_y; set flag. A second pulse in the same frame is ignored. The flag clears on startOfFrame.
- MOVING, startOfFrame, in order:
  (a) apply any same-cycle reflection;
  (b) pos += v (sign-extended);
  (c) clamp each pos to [MIN,MAX]<<FRAC_BITS; on clamp, negate that axis velocity;
  (d) v -= v>>>FRICTION_SHIFT (arithmetic);
  (e) if |v| < MIN_SPEED on an axis, that axis = 0.
  If both axes are 0 after (e): state IDLE, ball_stopped pulses 1 cycle.
- Negation of -1024 saturates to +1023.

Test Plan:
- Reset: assert resetN=1 mid-frame -> topLeftX=320, topLeftY=240, moving=0, strike_ready=1.
- Strike vx=+128, vy=0, then one startOfFrame -> topLeftX=322, internal vx=120. Subsequent frames decay to vx<16, then ball_stopped pulses once and moving=0.
- MOVING vx=+128; SingleHitPulse with hit_x=1, then a second pulse in the same frame -> vx=-128 (only one reflection); next frame topLeftX decreases by 2.
- SingleHitPulse and startOfFrame in the same cycle, vy=+64, hit_y=1 -> pos_y decreases by 64 (1 px), vy=-60.
- Ball at X=599, vx=+256, startOfFrame -> topLeftX clamps to 600, vx becomes negative.
- strike_valid while MOVING -> no velocity change; strike_valid with strike_vx=strike_vy=0 in IDLE -> stays IDLE.

Source files
------------

// File: rtl/ball_motion_controller.sv
// Ball kinematics: fixed-point position/velocity, per-frame integration with
// wall clamping, rolling friction, and one reflection per frame from the
// collision controller.
module ball_motion_controller #(
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int FRAC_BITS      = 6,
  parameter int FRICTION_SHIFT = 4,
  parameter int MIN_SPEED      = 16,
  parameter int X_MIN          = 32,
  parameter int X_MAX          = 600,
  parameter int Y_MIN          = 32,
  parameter int Y_MAX          = 440
) (
  input  logic               clk,
  input  logic               resetN,         // active-high despite the name
  input  logic               startOfFrame,
  input  logic               SingleHitPulse,
  input  logic               hit_x,
  input  logic               hit_y,
  input  logic               strike_valid,
  input  logic signed [10:0] strike_vx,
  input  logic signed [10:0] strike_vy,
  output logic               strike_ready,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               moving,
  output logic               ball_stopped
);

  localparam int W = 11 + FRAC_BITS;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MOVING = 1'b1;

  localparam logic signed [W-1:0] INIT_X_FP = W'(INIT_X << FRAC_BITS);
  localparam logic signed [W-1:0] INIT_Y_FP = W'(INIT_Y << FRAC_BITS);
  localparam logic signed [W-1:0] X_MIN_FP  = W'(X_MIN << FRAC_BITS);
  localparam logic signed [W-1:0] X_MAX_FP  = W'(X_MAX << FRAC_BITS);
  localparam logic signed [W-1:0] Y_MIN_FP  = W'(Y_MIN << FRAC_BITS);
  localparam logic signed [W-1:0] Y_MAX_FP  = W'(Y_MAX << FRAC_BITS);
  localparam logic signed [11:0]  MIN_SPD   = 12'(MIN_SPEED);

  typedef struct packed {
    logic signed [W-1:0] p;
    logic signed [10:0]  v;
  } axis_t;

  logic [0:0]         state_q, state_d;
  logic signed [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0]  vx_q, vx_d, vy_q, vy_d;
  logic               flag_q, flag_d;
  logic               stopped_q, stopped_d;
  logic               refl;
  axis_t              ax, ay;

  // -(-1024) does not fit in 11 bits; pin it to the largest positive value
  function automatic logic signed [10:0] neg_sat(input logic signed [10:0] v);
    return (v == {1'b1, 10'b0}) ? 11'sd1023 : -v;
  endfunction

  // One frame on one axis: reflect, integrate, clamp/bounce, friction, deadband
  function automatic axis_t axis_step(input logic signed [W-1:0] p,
                                      input logic signed [10:0]  v,
                                      input logic                flip,
                                      input logic signed [W-1:0] lo,
                                      input logic signed [W-1:0] hi);
    axis_t r;
    logic signed [10:0] vr;
    logic signed [11:0] mag;
    vr  = flip ? neg_sat(v) : v;
    r.p = p + {{FRAC_BITS{vr[10]}}, vr};
    r.v = vr;
    if (r.p > hi) begin
      r.p = hi;
      r.v = neg_sat(vr);
    end else if (r.p < lo) begin
      r.p = lo;
      r.v = neg_sat(vr);
    end
    r.v = r.v - (r.v >>> FRICTION_SHIFT);
    mag = r.v[10] ? -{r.v[10], r.v} : {r.v[10], r.v};
    if (mag < MIN_SPD) r.v = '0;
    return r;
  endfunction

  // Next-state: strike load in IDLE, reflection and frame update in MOVING
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    flag_d    = flag_q;
    stopped_d = 1'b0;
    refl      = SingleHitPulse && !flag_q;
    ax        = axis_step(pos_x_q, vx_q, refl && hit_x, X_MIN_FP, X_MAX_FP);
    ay        = axis_step(pos_y_q, vy_q, refl && hit_y, Y_MIN_FP, Y_MAX_FP);
    if (startOfFrame) flag_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (strike_valid && (strike_vx != '0 || strike_vy != '0)) begin
          vx_d    = strike_vx;
          vy_d    = strike_vy;
          state_d = MOVING;
        end
      end
      default: begin
        if (startOfFrame) begin
          pos_x_d = ax.p;
          pos_y_d = ay.p;
          vx_d    = ax.v;
          vy_d    = ay.v;
          if (ax.v == '0 && ay.v == '0) begin
            state_d   = IDLE;
            stopped_d = 1'b1;
          end
        end else if (refl) begin
          if (hit_x) vx_d = neg_sat(vx_q);
          if (hit_y) vy_d = neg_sat(vy_q);
          flag_d = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset respawns the ball at rest
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q   <= IDLE;
      pos_x_q   <= INIT_X_FP;
      pos_y_q   <= INIT_Y_FP;
      vx_q      <= '0;
      vy_q      <= '0;
      flag_q    <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      flag_q    <= flag_d;
      stopped_q <= stopped_d;
    end
  end

  assign topLeftX     = pos_x_q[W-1:FRAC_BITS];
  assign topLeftY     = pos_y_q[W-1:FRAC_BITS];
  assign moving       = (state_q == MOVING);
  assign strike_ready = (state_q == IDLE);
  assign ball_stopped = stopped_q;

endmodule

// File: tb/tb_ball_motion_controller.sv
// Bench for ball_motion_controller: directed scenarios followed by random
// frames, every cycle compared against an integer model of the ball.
module tb_ball_motion_controller;

  logic               clk = 1'b0;
  logic               resetN = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               SingleHitPulse = 1'b0;
  logic               hit_x = 1'b0;
  logic               hit_y = 1'b0;
  logic               strike_valid = 1'b0;
  logic signed [10:0] strike_vx = '0;
  logic signed [10:0] strike_vy = '0;
  logic               strike_ready;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               moving;
  logic               ball_stopped;

  int checks = 0;
  int errors = 0;

  // model state: position and velocity in 1/64 pixel units
  int  m_px, m_py, m_vx, m_vy;
  bit  m_mov, m_flag, m_stop;

  ball_motion_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .SingleHitPulse(SingleHitPulse), .hit_x(hit_x), .hit_y(hit_y),
    .strike_valid(strike_valid), .strike_vx(strike_vx), .strike_vy(strike_vy),
    .strike_ready(strike_ready), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .moving(moving), .ball_stopped(ball_stopped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int nsat(input int v);
    return (v == -1024) ? 1023 : -v;
  endfunction

  // one frame of motion along one axis, straight from the rules
  task automatic m_axis(inout int p, inout int v, input int lo, input int hi);
    p = p + v;
    if (p > hi * 64)      begin p = hi * 64; v = nsat(v); end
    else if (p < lo * 64) begin p = lo * 64; v = nsat(v); end
    v = v - (v >>> 4);
    if ((v < 0 ? -v : v) < 16) v = 0;
  endtask

  task automatic m_reset();
    m_px = 320 * 64; m_py = 240 * 64; m_vx = 0; m_vy = 0;
    m_mov = 0; m_flag = 0; m_stop = 0;
  endtask

  task automatic m_clock(input bit sof, hit, hx, hy, sv, input int svx, svy);
    bool_refl: begin end
    m_stop = 0;
    if (!m_mov) begin
      if (sv && (svx != 0 || svy != 0)) begin
        m_vx = svx; m_vy = svy; m_mov = 1;
      end
    end else begin
      if (hit && !m_flag) begin
        if (hx) m_vx = nsat(m_vx);
        if (hy) m_vy = nsat(m_vy);
        if (!sof) m_flag = 1;
      end
      if (sof) begin
        m_axis(m_px, m_vx, 32, 600);
        m_axis(m_py, m_vy, 32, 440);
        if (m_vx == 0 && m_vy == 0) begin m_mov = 0; m_stop = 1; end
      end
    end
    if (sof) m_flag = 0;
  endtask

  task automatic compare_all();
    chk("topLeftX", topLeftX, m_px >>> 6);
    chk("topLeftY", topLeftY, m_py >>> 6);
    chk("vx", dut.vx_q, m_vx);
    chk("vy", dut.vy_q, m_vy);
    chk("moving", moving, int'(m_mov));
    chk("strike_ready", strike_ready, int'(!m_mov));
    chk("ball_stopped", ball_stopped, int'(m_stop));
  endtask

  task automatic cyc(input bit sof, hit, hx, hy, sv, input int svx, svy);
    startOfFrame = sof; SingleHitPulse = hit; hit_x = hx; hit_y = hy;
    strike_valid = sv; strike_vx = 11'(svx); strike_vy = 11'(svy);
    @(posedge clk);
    m_clock(sof, hit, hx, hy, sv, svx, svy);
    #1;
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame();
    idle_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    #1;
    m_reset();
    chk("rst_tlx", topLeftX, 320);
    chk("rst_tly", topLeftY, 240);
    chk("rst_moving", moving, 0);
    chk("rst_ready", strike_ready, 1);
    chk("rst_stopped", ball_stopped, 0);
    @(negedge clk);
    resetN = 1'b0;
  endtask

  // run frames until the model stops, counting stop pulses from the DUT
  task automatic run_to_stop(input string tag);
    int pulses = 0;
    for (int f = 0; f < 300 && m_mov; f++) begin
      frame();
      if (ball_stopped) pulses++;
    end
    chk({tag, "_stop_bound"}, int'(m_mov), 0);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_moving"}, moving, 0);
  endtask

  initial begin
    int x0, seen;
    m_reset();
    @(negedge clk);
    resetN = 1'b0;

    // basic strike and friction decay
    cyc(0, 0, 0, 0, 1, 128, 0);
    chk("strike_moving", moving, 1);
    chk("strike_ready_low", strike_ready, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("first_frame_tlx", topLeftX, 322);
    chk("first_frame_vx", dut.vx_q, 120);
    run_to_stop("decay");
    idle_cyc();
    chk("stop_pulse_once", ball_stopped, 0);

    // reset mid-motion aborts without a stop pulse
    cyc(0, 0, 0, 0, 1, 300, -200);
    frame();
    frame();
    do_reset();

    // single reflection per frame
    cyc(0, 0, 0, 0, 1, 128, 0);
    frame();
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("one_reflect_vx", dut.vx_q, -120);
    x0 = topLeftX;
    do_reset();
    cyc(0, 0, 0, 0, 1, 128, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("reflect_vx", dut.vx_q, -128);
    x0 = topLeftX;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reflect_dx", topLeftX, x0 - 2);

    // reflection coincident with frame start
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 64);
    cyc(1, 1, 0, 1, 0, 0, 0);
    chk("sof_hit_tly", topLeftY, 239);
    chk("sof_hit_vy", dut.vy_q, -60);

    // strike ignored while moving
    cyc(0, 0, 0, 0, 1, 500, 500);
    chk("strike_ignored_vx", dut.vx_q, 0);
    chk("strike_ignored_vy", dut.vy_q, -60);
    run_to_stop("ystop");

    // zero strike ignored in IDLE
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("zero_strike_moving", moving, 0);

    // wall clamp at X_MAX: two hard strikes to the right
    do_reset();
    cyc(0, 0, 0, 0, 1, 1023, 0);
    run_to_stop("clamp1");
    cyc(0, 0, 0, 0, 1, 1023, 0);
    seen = 0;
    for (int f = 0; f < 300 && m_mov && !seen; f++) begin
      frame();
      if (m_px == 600 * 64) seen = 1;
    end
    chk("clamp_reached", seen, 1);
    chk("clamp_tlx", topLeftX, 600);
    chk("clamp_vx_neg", int'(dut.vx_q < 0), 1);
    run_to_stop("clamp2");

    // random frames, strikes, hits
    do_reset();
    for (int f = 0; f < 1500; f++) begin
      int len = $urandom_range(1, 5);
      for (int c = 0; c < len; c++) begin
        bit sv  = ($urandom_range(0, 3) == 0);
        bit hit = ($urandom_range(0, 2) == 0);
        int svx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2047)) - 1024;
        int svy = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2047)) - 1024;
        cyc(c == len - 1, hit, 1'($urandom), 1'($urandom), sv, svx, svy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
